// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 3x3 convolution datapath: default data widths,
// the window side, the core's accumulated result width and the feeder FSM
// state encoding. Imported by the feeder, the core and downstream stages.
// ----------------------------------------------------------------------------
package conv_pkg;

    localparam int BIT_LEN  = 8;  // pixel / coefficient width
    localparam int M_LEN    = 3;  // window side (only 3 is supported)
    // Sum of nine BIT_LEN x BIT_LEN products needs 2*BIT_LEN + ceil(log2(9)) bits.
    localparam int CONV_LEN = 2 * BIT_LEN + $clog2(M_LEN * M_LEN);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_K0,
        ST_LOAD_K1,
        ST_LOAD_K2,
        ST_STREAM,
        ST_EMIT0,
        ST_EMIT1,
        ST_EMIT2,
        ST_DRAIN
    } state_t;

    // True in the three states that drive image-row beats to the core.
    function automatic logic is_emit(state_t s);
        return (s == ST_EMIT0) || (s == ST_EMIT1) || (s == ST_EMIT2);
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// ----------------------------------------------------------------------------
// conv_line_buffer
// Holds the two previous image lines and the 3x3 window built from them.
// On every accepted pixel at column i_x:
//   - lb0[i_x] (row y-2) and lb1[i_x] (row y-1) are read,
//   - lb0[i_x] <= lb1[i_x], lb1[i_x] <= i_pix (the lines roll down one row),
//   - the top/mid/bottom column registers shift in lb0[i_x]/lb1[i_x]/i_pix.
// Window element [2] is column x (newest), [1] is x-1, [0] is x-2.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      synchronous active-low reset (clears column registers only)
//   i_accept     pixel accepted this cycle
//   i_row_start  accepted pixel is column 0: older columns are cleared
//   i_x          column of the accepted pixel
//   i_pix        pixel value
//   o_win_top    row y-2, columns x-2..x
//   o_win_mid    row y-1, columns x-2..x
//   o_win_bot    row y,   columns x-2..x
// ----------------------------------------------------------------------------
module conv_line_buffer #(
    parameter int BIT_LEN = 8,
    parameter int IMG_W   = 8,
    parameter int CW      = $clog2(IMG_W)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_accept,
    input  logic                    i_row_start,
    input  logic [CW-1:0]           i_x,
    input  logic [BIT_LEN-1:0]      i_pix,
    output logic [2:0][BIT_LEN-1:0] o_win_top,
    output logic [2:0][BIT_LEN-1:0] o_win_mid,
    output logic [2:0][BIT_LEN-1:0] o_win_bot
);

    logic [BIT_LEN-1:0] r_lb0 [IMG_W];
    logic [BIT_LEN-1:0] r_lb1 [IMG_W];

    logic [2:0][BIT_LEN-1:0] r_top;
    logic [2:0][BIT_LEN-1:0] r_mid;
    logic [2:0][BIT_LEN-1:0] r_bot;

    logic [BIT_LEN-1:0] w_lb0_rd;
    logic [BIT_LEN-1:0] w_lb1_rd;

    assign w_lb0_rd = r_lb0[i_x];
    assign w_lb1_rd = r_lb1[i_x];

    // NOTE: the line arrays are deliberately left out of reset so they map to
    // plain storage; every entry is rewritten during rows 0 and 1 before any
    // window reads it.
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_accept) begin
            r_lb0[i_x] <= w_lb1_rd;
            r_lb1[i_x] <= i_pix;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_top <= '0;
            r_mid <= '0;
            r_bot <= '0;
        end else if (i_accept) begin
            if (i_row_start) begin
                // Drop the previous row's columns so windows never mix rows.
                r_top <= {w_lb0_rd, {(2 * BIT_LEN){1'b0}}};
                r_mid <= {w_lb1_rd, {(2 * BIT_LEN){1'b0}}};
                r_bot <= {i_pix,    {(2 * BIT_LEN){1'b0}}};
            end else begin
                r_top <= {w_lb0_rd, r_top[2:1]};
                r_mid <= {w_lb1_rd, r_mid[2:1]};
                r_bot <= {i_pix,    r_bot[2:1]};
            end
        end
    end

    assign o_win_top = r_top;
    assign o_win_mid = r_mid;
    assign o_win_bot = r_bot;

endmodule

// File: rtl/conv_window_feeder.sv
// ----------------------------------------------------------------------------
// conv_window_feeder
// Upstream stage of the 3x3 convolution core. Captures a kernel on i_start,
// loads it into the core as three kernel-row beats, then accepts a raster
// pixel stream. Each pixel that completes a valid-mode window stalls the
// stream for three image-row beats (top, mid, bottom). A two-stage strobe
// pipeline raises o_res_valid, tagged with the window's right column and
// bottom row, in the cycle the core's o_data holds that window's sum.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      synchronous active-low reset
//   i_start      frame start, sampled only in IDLE
//   i_kernel     k0..k8 raster order, k0 in LSBs
//   i_pix_valid  pixel offered
//   i_pix        pixel, raster order
//   o_pix_ready  pixel accepted when i_pix_valid & o_pix_ready
//   o_valid      core i_valid
//   o_selecK_I   0 = kernel row, 1 = image row
//   o_data0/1/2  left / centre / right element of the row beat
//   o_res_valid  core o_data is valid this cycle
//   o_res_x      window right column
//   o_res_y      window bottom row
//   o_busy       high outside IDLE
//   o_done       one-cycle pulse with the frame's last result strobe
// ----------------------------------------------------------------------------
module conv_window_feeder #(
    parameter int BIT_LEN = conv_pkg::BIT_LEN,
    parameter int M_LEN   = conv_pkg::M_LEN,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int CW      = $clog2(IMG_W),
    parameter int RW      = $clog2(IMG_H)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [9*BIT_LEN-1:0] i_kernel,
    input  logic                 i_pix_valid,
    input  logic [BIT_LEN-1:0]   i_pix,
    output logic                 o_pix_ready,
    output logic                 o_valid,
    output logic                 o_selecK_I,
    output logic [BIT_LEN-1:0]   o_data0,
    output logic [BIT_LEN-1:0]   o_data1,
    output logic [BIT_LEN-1:0]   o_data2,
    output logic                 o_res_valid,
    output logic [CW-1:0]        o_res_x,
    output logic [RW-1:0]        o_res_y,
    output logic                 o_busy,
    output logic                 o_done
);

    import conv_pkg::*;

    localparam logic [CW-1:0] X_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] Y_LAST  = RW'(IMG_H - 1);
    // First column / row at which a full window exists.
    localparam logic [CW-1:0] X_FIRST = CW'(M_LEN - 1);
    localparam logic [RW-1:0] Y_FIRST = RW'(M_LEN - 1);

    state_t r_state;
    state_t w_state_next;

    logic [8:0][BIT_LEN-1:0] r_kernel;
    logic [CW-1:0]           r_x;
    logic [RW-1:0]           r_y;
    logic [CW-1:0]           r_lat_x;
    logic [RW-1:0]           r_lat_y;

    // Strobe pipeline: stage 1 mirrors the core's multiply register, stage 2
    // is the cycle its combinational sum is valid.
    logic                    r_p1_valid;
    logic [CW-1:0]           r_p1_x;
    logic [RW-1:0]           r_p1_y;
    logic                    r_res_valid;
    logic [CW-1:0]           r_res_x;
    logic [RW-1:0]           r_res_y;

    logic                    w_accept;
    logic                    w_win_ready;
    logic                    w_row_start;
    logic                    w_last_window;

    logic [2:0][BIT_LEN-1:0] w_win_top;
    logic [2:0][BIT_LEN-1:0] w_win_mid;
    logic [2:0][BIT_LEN-1:0] w_win_bot;

    assign w_win_ready   = (r_x >= X_FIRST) && (r_y >= Y_FIRST);
    assign w_row_start   = (r_x == '0);
    assign w_last_window = (r_lat_x == X_LAST) && (r_lat_y == Y_LAST);

    conv_line_buffer #(
        .BIT_LEN (BIT_LEN),
        .IMG_W   (IMG_W),
        .CW      (CW)
    ) u_line_buffer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_accept    (w_accept),
        .i_row_start (w_row_start),
        .i_x         (r_x),
        .i_pix       (i_pix),
        .o_win_top   (w_win_top),
        .o_win_mid   (w_win_mid),
        .o_win_bot   (w_win_bot)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs. All outputs decode the registered state
    // and registered data; only the next state looks at i_pix_valid.
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        o_pix_ready  = 1'b0;
        o_valid      = 1'b0;
        o_selecK_I   = is_emit(r_state);
        o_data0      = '0;
        o_data1      = '0;
        o_data2      = '0;
        o_done       = 1'b0;
        o_busy       = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_LOAD_K0;
                end
            end
            ST_LOAD_K0: begin
                o_valid      = 1'b1;
                o_data0      = r_kernel[0];
                o_data1      = r_kernel[1];
                o_data2      = r_kernel[2];
                w_state_next = ST_LOAD_K1;
            end
            ST_LOAD_K1: begin
                o_valid      = 1'b1;
                o_data0      = r_kernel[3];
                o_data1      = r_kernel[4];
                o_data2      = r_kernel[5];
                w_state_next = ST_LOAD_K2;
            end
            ST_LOAD_K2: begin
                o_valid      = 1'b1;
                o_data0      = r_kernel[6];
                o_data1      = r_kernel[7];
                o_data2      = r_kernel[8];
                w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                o_pix_ready = 1'b1;
                w_accept    = i_pix_valid;
                if (i_pix_valid && w_win_ready) begin
                    w_state_next = ST_EMIT0;
                end
            end
            ST_EMIT0: begin
                o_valid      = 1'b1;
                o_data0      = w_win_top[0];
                o_data1      = w_win_top[1];
                o_data2      = w_win_top[2];
                w_state_next = ST_EMIT1;
            end
            ST_EMIT1: begin
                o_valid      = 1'b1;
                o_data0      = w_win_mid[0];
                o_data1      = w_win_mid[1];
                o_data2      = w_win_mid[2];
                w_state_next = ST_EMIT2;
            end
            ST_EMIT2: begin
                o_valid      = 1'b1;
                o_data0      = w_win_bot[0];
                o_data1      = w_win_bot[1];
                o_data2      = w_win_bot[2];
                w_state_next = w_last_window ? ST_DRAIN : ST_STREAM;
            end
            ST_DRAIN: begin
                // The last window's strobe is the end of the frame.
                if (r_res_valid) begin
                    o_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Kernel capture, raster counters and window coordinate latch
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_kernel <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_lat_x  <= '0;
            r_lat_y  <= '0;
        end else begin
            if (r_state == ST_IDLE && i_start) begin
                r_kernel <= i_kernel;
                r_x      <= '0;
                r_y      <= '0;
            end
            if (w_accept) begin
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
                if (w_win_ready) begin
                    r_lat_x <= r_x;
                    r_lat_y <= r_y;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result strobe pipeline. Coordinates are copied out of the latch at
    // EMIT2 because the next accepted pixel may overwrite the latch before
    // this window's strobe appears.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_p1_valid  <= 1'b0;
            r_p1_x      <= '0;
            r_p1_y      <= '0;
            r_res_valid <= 1'b0;
            r_res_x     <= '0;
            r_res_y     <= '0;
        end else begin
            r_p1_valid  <= (r_state == ST_EMIT2);
            r_res_valid <= r_p1_valid;
            if (r_state == ST_EMIT2) begin
                r_p1_x <= r_lat_x;
                r_p1_y <= r_lat_y;
            end
            if (r_p1_valid) begin
                r_res_x <= r_p1_x;
                r_res_y <= r_p1_y;
            end
        end
    end

    assign o_res_valid = r_res_valid;
    assign o_res_x     = r_res_x;
    assign o_res_y     = r_res_y;

endmodule

// File: tb/tb_conv_window_feeder.sv
// ----------------------------------------------------------------------------
// tb_conv_window_feeder
// Bench for conv_window_feeder on a 4x4 image. A small model of the 3x3 core
// collects the kernel and image row beats, forms each window's sum and
// expects the result strobe two cycles after the third image beat.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_window_feeder;

    localparam int BL = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 2;
    localparam int RW = 2;
    localparam int NPIX = W * H;
    localparam int NRES = (W - 2) * (H - 2);

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_start = 1'b0;
    logic [9*BL-1:0]   i_kernel = '0;
    logic              i_pix_valid = 1'b0;
    logic [BL-1:0]     i_pix = '0;
    logic              o_pix_ready;
    logic              o_valid;
    logic              o_selecK_I;
    logic [BL-1:0]     o_data0;
    logic [BL-1:0]     o_data1;
    logic [BL-1:0]     o_data2;
    logic              o_res_valid;
    logic [CW-1:0]     o_res_x;
    logic [RW-1:0]     o_res_y;
    logic              o_busy;
    logic              o_done;

    always #5 i_clk = ~i_clk;

    conv_window_feeder #(
        .BIT_LEN (BL),
        .M_LEN   (3),
        .IMG_W   (W),
        .IMG_H   (H),
        .CW      (CW),
        .RW      (RW)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_kernel    (i_kernel),
        .i_pix_valid (i_pix_valid),
        .i_pix       (i_pix),
        .o_pix_ready (o_pix_ready),
        .o_valid     (o_valid),
        .o_selecK_I  (o_selecK_I),
        .o_data0     (o_data0),
        .o_data1     (o_data1),
        .o_data2     (o_data2),
        .o_res_valid (o_res_valid),
        .o_res_x     (o_res_x),
        .o_res_y     (o_res_y),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Core model and observation
    // ------------------------------------------------------------------
    typedef struct {
        int x;
        int y;
        int sum;
    } res_t;

    res_t        results[$];
    int          cyc = 0;
    bit          pend = 1'b0;
    int          pend_cyc = 0;
    int          pend_sum = 0;
    int          kr[3][3];
    int          ir[3][3];
    int          kidx = 0;
    int          eidx = 0;
    int          done_cnt = 0;
    int          acc_cnt = 0;
    int          kbeats = 0;
    int          win_cnt = 0;
    bit          done_on_strobe = 1'b0;
    bit          acc = 1'b0;
    logic [23:0] first_beats[3];

    always @(negedge i_clk) begin
        cyc++;
        // Inputs are stable here; this is the accept decision of the next edge.
        acc = i_pix_valid && o_pix_ready;
        if (!i_reset) begin
            kidx = 0;
            eidx = 0;
            pend = 1'b0;
        end else begin
            if (acc) acc_cnt++;
            if (pend && cyc == pend_cyc) begin
                check("strobe_timing", o_res_valid, 1);
                if (o_res_valid) begin
                    results.push_back('{int'(o_res_x), int'(o_res_y), pend_sum});
                end
                pend = 1'b0;
            end else if (o_res_valid) begin
                check("spurious_strobe", o_res_valid, 0);
            end
            if (o_done) begin
                done_cnt++;
                done_on_strobe = o_res_valid;
            end
            if (o_valid && !o_selecK_I) begin
                kbeats++;
                if (kidx < 3) begin
                    kr[kidx][0] = int'(o_data0);
                    kr[kidx][1] = int'(o_data1);
                    kr[kidx][2] = int'(o_data2);
                    kidx++;
                end
            end
            if (o_valid && o_selecK_I) begin
                ir[eidx][0] = int'(o_data0);
                ir[eidx][1] = int'(o_data1);
                ir[eidx][2] = int'(o_data2);
                if (win_cnt == 0) first_beats[eidx] = {o_data2, o_data1, o_data0};
                eidx++;
                if (eidx == 3) begin
                    pend_sum = 0;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            pend_sum += kr[r][c] * ir[r][c];
                    pend     = 1'b1;
                    pend_cyc = cyc + 2;
                    eidx     = 0;
                    win_cnt++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Vector table for reset and kernel load
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        bit          rst_n;
        bit          start;
        bit          pv;
        logic [29:0] exp;
    } vec_t;

    function automatic logic [29:0] po(bit v, bit s, int d2, int d1, int d0,
                                       bit rdy, bit busy, bit done, bit rv);
        return {v, s, 8'(d2), 8'(d1), 8'(d0), rdy, busy, done, rv};
    endfunction

    function automatic vec_t mk(string n, bit r, bit s, bit pv, logic [29:0] e);
        vec_t t;
        t.name  = n;
        t.rst_n = r;
        t.start = s;
        t.pv    = pv;
        t.exp   = e;
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(posedge i_clk); #2;
        i_reset     = 1'b0;
        i_start     = 1'b0;
        i_pix_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        i_reset = 1'b1;
    endtask

    task automatic clear_stats();
        results.delete();
        done_cnt       = 0;
        acc_cnt        = 0;
        kbeats         = 0;
        win_cnt        = 0;
        done_on_strobe = 1'b0;
        for (int i = 0; i < 3; i++) first_beats[i] = '0;
    endtask

    task automatic start_frame(input logic [9*BL-1:0] k);
        @(posedge i_clk); #2;
        i_start  = 1'b1;
        i_kernel = k;
        @(posedge i_clk); #2;
        i_start  = 1'b0;
    endtask

    // Offers pixels 0..stop_after-1 (pixel value = x + 4y = raster index),
    // holding each until accepted.
    task automatic feed_pixels(input bit rnd, input int stop_after,
                               input bit busy_start, input string tag);
        int p;
        int guard;
        bit busy_sent;
        p = 0;
        guard = 0;
        busy_sent = 1'b0;
        while (p < stop_after && guard < 3000) begin
            @(posedge i_clk); #2;
            if (acc) p++;
            i_start = 1'b0;
            if (p < stop_after) begin
                i_pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                i_pix       = BL'(p);
                if (busy_start && p == 5 && !busy_sent) begin
                    i_start   = 1'b1;
                    i_kernel  = {9{8'd2}};
                    busy_sent = 1'b1;
                end
            end else begin
                i_pix_valid = 1'b0;
            end
            guard++;
        end
        i_pix_valid = 1'b0;
        i_start     = 1'b0;
        check({tag, "_feed_timeout"}, guard < 3000, 1);
    endtask

    // Required strobes for all-ones kernel, pixel = x + 4y.
    res_t        exp_res[NRES];
    logic [23:0] exp_beats[3];

    task automatic run_frame(input bit rnd, input bit busy_start, input string tag);
        int guard;
        do_reset();
        clear_stats();
        start_frame({9{8'd1}});
        feed_pixels(rnd, NPIX, busy_start, tag);
        guard = 0;
        while (done_cnt == 0 && guard < 60) begin
            @(posedge i_clk); #2;
            guard++;
        end
        check({tag, "_done_timeout"}, guard < 60, 1);
        @(posedge i_clk); #2;
        check({tag, "_idle_after_done"}, o_busy, 0);
        check({tag, "_result_count"}, results.size(), NRES);
        for (int i = 0; i < NRES; i++) begin
            if (i < results.size()) begin
                check($sformatf("%s_res%0d_xy", tag, i),
                      {results[i].x[7:0], results[i].y[7:0]},
                      {exp_res[i].x[7:0], exp_res[i].y[7:0]});
                check($sformatf("%s_res%0d_sum", tag, i), results[i].sum, exp_res[i].sum);
            end
        end
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_on_last_strobe"}, done_on_strobe, 1);
        check({tag, "_pixels_accepted"}, acc_cnt, NPIX);
        check({tag, "_kernel_beats"}, kbeats, 3);
        for (int r = 0; r < 3; r++)
            check($sformatf("%s_first_win_beat%0d", tag, r), first_beats[r], exp_beats[r]);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    vec_t vecs[8];
    logic [9*BL-1:0] k_1to9;

    initial begin
        k_1to9 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

        exp_res[0] = '{2, 2, 45};
        exp_res[1] = '{3, 2, 54};
        exp_res[2] = '{2, 3, 81};
        exp_res[3] = '{3, 3, 90};
        exp_beats[0] = {8'd2,  8'd1, 8'd0};
        exp_beats[1] = {8'd6,  8'd5, 8'd4};
        exp_beats[2] = {8'd10, 8'd9, 8'd8};

        vecs[0] = mk("reset_c0",        0, 0, 0, po(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs[1] = mk("reset_start_c1",  0, 1, 0, po(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs[2] = mk("reset_pv_c2",     0, 0, 1, po(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs[3] = mk("load_k0",         1, 1, 0, po(1, 0, 3, 2, 1, 0, 1, 0, 0));
        vecs[4] = mk("load_k1",         1, 0, 0, po(1, 0, 6, 5, 4, 0, 1, 0, 0));
        vecs[5] = mk("load_k2",         1, 0, 0, po(1, 0, 9, 8, 7, 0, 1, 0, 0));
        vecs[6] = mk("stream_entry",    1, 0, 0, po(0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs[7] = mk("stream_start_ign",1, 1, 0, po(0, 0, 0, 0, 0, 1, 1, 0, 0));

        // Inputs applied after one edge are checked just after the next.
        @(posedge i_clk); #2;
        for (int i = 0; i < 8; i++) begin
            i_reset     = vecs[i].rst_n;
            i_start     = vecs[i].start;
            i_pix_valid = vecs[i].pv;
            i_kernel    = k_1to9;
            @(posedge i_clk); #2;
            check(vecs[i].name,
                  {o_valid, o_selecK_I, o_data2, o_data1, o_data0,
                   o_pix_ready, o_busy, o_done, o_res_valid},
                  vecs[i].exp);
        end
        i_start = 1'b0;

        // Full frame, valid held high.
        run_frame(1'b0, 1'b0, "frame");

        // Same frame with random valid gaps.
        run_frame(1'b1, 1'b0, "stall");

        // Abandon a frame after 7 accepted pixels.
        do_reset();
        clear_stats();
        start_frame({9{8'd1}});
        feed_pixels(1'b0, 7, 1'b0, "abort");
        check("abort_pixels_accepted", acc_cnt, 7);
        do_reset();
        repeat (20) @(posedge i_clk);
        #2;
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", o_busy, 0);
        check("abort_no_results", results.size(), 0);

        // Restart reproduces the frame.
        run_frame(1'b0, 1'b0, "restart");

        // i_start with another kernel during STREAM must be ignored.
        run_frame(1'b0, 1'b1, "busy_start");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
